ball_motion: RTL and testbench

Ball position and direction controller for the Breakout playfield, sitting directly downstream of the ball timer. Each single-cycle `tick` from the timer advances the ball by `STEP` pixels per axis. Walls, the paddle and brick-hit requests from the collision logic reflect the ball. A miss below the paddle reports a lost ball. Outputs feed the renderer and the brick collision logic.

---
 rtl/ball_motion.sv | 174 +++++++++++++++++
 tb/tb_ball_motion.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// Ball position/direction controller for the Breakout playfield.
// Tracks the paddle while idle, moves STEP pixels per axis on each timer
// tick once launched, reflects off walls, paddle and brick-hit requests,
// and pulses ball_lost for one cycle when the ball drops past the paddle.
//
// Pulse semantics (no valid/ready handshake here): tick, launch,
// brick_hit_x and brick_hit_y are sampled on every rising clock edge and
// act in that cycle only. Brick hits seen between ticks are remembered in
// sticky pending flags and applied once, at the next tick.
module ball_motion #(
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned PADDLE_Y  = 440,
  parameter int unsigned PADDLE_W  = 64,
  parameter int unsigned STEP      = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       launch,
  input  logic [9:0] paddle_x,
  input  logic       brick_hit_x,
  input  logic       brick_hit_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       moving,
  output logic       ball_lost,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    LOST   = 2'd2
  } state_t;

  // All geometry is compared at 11 bits so sums near the screen edge cannot wrap.
  localparam logic [10:0] STEP11   = 11'(STEP);
  localparam logic [10:0] SIZE11   = 11'(BALL_SIZE);
  localparam logic [10:0] X_MAX    = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_MAX    = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] PAD_Y    = 11'(PADDLE_Y);
  localparam logic [10:0] PAD_W    = 11'(PADDLE_W);
  localparam logic [10:0] REST_Y   = 11'(PADDLE_Y - BALL_SIZE);
  localparam logic [10:0] HALF_OFF = 11'(PADDLE_W / 2 - BALL_SIZE / 2);

  state_t state;
  logic   pending_x, pending_y;

  logic [10:0] x11, y11, px11;
  logic        eff_dx, eff_dy;
  logic [9:0]  nx, ny, track_x;
  logic        ndx, ndy, paddle_hit, miss;

  assign dbg_state = state;

  // Next position/direction for a tick in MOVING: flip first, then move.
  always_comb begin
    x11        = {1'b0, ball_x};
    y11        = {1'b0, ball_y};
    px11       = {1'b0, paddle_x};
    track_x    = 10'(px11 + HALF_OFF);
    eff_dx     = dir_x ^ (pending_x | brick_hit_x);
    eff_dy     = dir_y ^ (pending_y | brick_hit_y);
    nx         = ball_x;
    ny         = ball_y;
    ndx        = eff_dx;
    ndy        = eff_dy;
    paddle_hit = 1'b0;
    miss       = 1'b0;

    if (eff_dx) begin
      if (x11 + STEP11 >= X_MAX) begin
        nx  = 10'(X_MAX);
        ndx = 1'b0;
      end else begin
        nx = 10'(x11 + STEP11);
      end
    end else begin
      if (x11 <= STEP11) begin
        nx  = 10'd0;
        ndx = 1'b1;
      end else begin
        nx = 10'(x11 - STEP11);
      end
    end

    if (!eff_dy) begin
      if (y11 <= STEP11) begin
        ny  = 10'd0;
        ndy = 1'b1;
      end else begin
        ny = 10'(y11 - STEP11);
      end
    end else begin
      paddle_hit = (y11 + SIZE11 <= PAD_Y) &&
                   (y11 + STEP11 + SIZE11 >= PAD_Y) &&
                   (x11 + SIZE11 > px11) &&
                   (x11 < px11 + PAD_W);
      if (paddle_hit) begin
        ny  = 10'(REST_Y);
        ndy = 1'b0;
      end else if (y11 + STEP11 >= Y_MAX) begin
        ny   = 10'(Y_MAX);
        miss = 1'b1;
      end else begin
        ny = 10'(y11 + STEP11);
      end
    end
  end

  // State machine with registered outputs and sticky brick-hit flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ball_x    <= 10'd0;
      ball_y    <= 10'(REST_Y);
      dir_x     <= 1'b1;
      dir_y     <= 1'b0;
      moving    <= 1'b0;
      ball_lost <= 1'b0;
      pending_x <= 1'b0;
      pending_y <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ball_x    <= track_x;
          ball_y    <= 10'(REST_Y);
          pending_x <= 1'b0;
          pending_y <= 1'b0;
          ball_lost <= 1'b0;
          if (launch) begin
            state  <= MOVING;
            dir_x  <= 1'b1;
            dir_y  <= 1'b0;
            moving <= 1'b1;
          end
        end
        MOVING: begin
          if (tick) begin
            ball_x    <= nx;
            ball_y    <= ny;
            dir_x     <= ndx;
            dir_y     <= ndy;
            pending_x <= 1'b0;
            pending_y <= 1'b0;
            if (miss) begin
              state     <= LOST;
              moving    <= 1'b0;
              ball_lost <= 1'b1;
            end
          end else begin
            pending_x <= pending_x | brick_hit_x;
            pending_y <= pending_y | brick_hit_y;
          end
        end
        LOST: begin
          state     <= IDLE;
          ball_lost <= 1'b0;
          moving    <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          moving    <= 1'b0;
          ball_lost <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Directed testbench for ball_motion: an idle-tracking vector table plus
// hand-computed trajectory sequences (walls, bricks, paddle hit and miss,
// asynchronous reset).
module tb_ball_motion;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       launch;
  logic [9:0] paddle_x;
  logic       brick_hit_x;
  logic       brick_hit_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       dir_x;
  logic       dir_y;
  logic       moving;
  logic       ball_lost;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  ball_motion dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .launch      (launch),
    .paddle_x    (paddle_x),
    .brick_hit_x (brick_hit_x),
    .brick_hit_y (brick_hit_y),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .dir_x       (dir_x),
    .dir_y       (dir_y),
    .moving      (moving),
    .ball_lost   (ball_lost),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [9:0] px;
    logic       tk;
    logic       hx;
    logic       hy;
    logic [9:0] exp_x;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n clock edges; outputs are then sampled 1 time unit after the edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    cyc(n);
    tick = 1'b0;
  endtask

  task automatic check_pos(input string name, input int ex, input int ey);
    check({name, "_x"}, 16'(ball_x), 16'(ex));
    check({name, "_y"}, 16'(ball_y), 16'(ey));
  endtask

  initial begin
    vecs[0] = '{px: 10'd288, tk: 1'b0, hx: 1'b0, hy: 1'b0, exp_x: 10'd316};
    vecs[1] = '{px: 10'd100, tk: 1'b0, hx: 1'b0, hy: 1'b0, exp_x: 10'd128};
    vecs[2] = '{px: 10'd0,   tk: 1'b1, hx: 1'b0, hy: 1'b0, exp_x: 10'd28};
    vecs[3] = '{px: 10'd576, tk: 1'b1, hx: 1'b1, hy: 1'b1, exp_x: 10'd604};
    vecs[4] = '{px: 10'd37,  tk: 1'b0, hx: 1'b1, hy: 1'b0, exp_x: 10'd65};
    vecs[5] = '{px: 10'd288, tk: 1'b1, hx: 1'b0, hy: 1'b1, exp_x: 10'd316};

    reset       = 1'b0;
    tick        = 1'b0;
    launch      = 1'b0;
    paddle_x    = 10'd288;
    brick_hit_x = 1'b0;
    brick_hit_y = 1'b0;
    #12;
    check_pos("rst", 0, 432);
    check("rst_dir_x", 16'(dir_x), 16'd1);
    check("rst_dir_y", 16'(dir_y), 16'd0);
    check("rst_moving", 16'(moving), 16'd0);
    check("rst_lost", 16'(ball_lost), 16'd0);

    // Idle tracking; ticks and brick hits must not disturb the ball.
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      paddle_x    = vecs[i].px;
      tick        = vecs[i].tk;
      brick_hit_x = vecs[i].hx;
      brick_hit_y = vecs[i].hy;
      cyc(1);
      check_pos($sformatf("idle%0d", i), int'(vecs[i].exp_x), 432);
      check($sformatf("idle%0d_moving", i), 16'(moving), 16'd0);
    end
    tick        = 1'b0;
    brick_hit_x = 1'b0;
    brick_hit_y = 1'b0;

    // Launch with a coincident tick: tick ignored, moving next cycle.
    paddle_x = 10'd288;
    launch   = 1'b1;
    tick     = 1'b1;
    cyc(1);
    launch = 1'b0;
    tick   = 1'b0;
    check_pos("launch", 316, 432);
    check("launch_moving", 16'(moving), 16'd1);
    check("launch_state", 16'(dbg_state), 16'd1);

    // Three ticks; launch held during MOVING is ignored.
    launch = 1'b1;
    ticks(3);
    launch = 1'b0;
    check_pos("step3", 319, 429);
    check("step3_dir_x", 16'(dir_x), 16'd1);
    check("step3_dir_y", 16'(dir_y), 16'd0);

    // Pending brick_hit_y 5 cycles before a tick, moving up at y=200.
    ticks(229);
    check_pos("pre_brick", 548, 200);
    brick_hit_y = 1'b1;
    cyc(1);
    brick_hit_y = 1'b0;
    cyc(4);
    check_pos("pending_hold", 548, 200);
    ticks(1);
    check_pos("brick_y", 549, 201);
    check("brick_y_dir", 16'(dir_y), 16'd1);

    // Two hits between ticks collapse into one toggle.
    brick_hit_y = 1'b1; cyc(1);
    brick_hit_y = 1'b0; cyc(1);
    brick_hit_y = 1'b1; cyc(1);
    brick_hit_y = 1'b0; cyc(1);
    ticks(1);
    check_pos("collapse", 550, 200);
    check("collapse_dir", 16'(dir_y), 16'd0);

    // Right wall.
    ticks(81);
    check_pos("rwall_pre", 631, 119);
    ticks(1);
    check_pos("rwall", 632, 118);
    check("rwall_dir", 16'(dir_x), 16'd0);
    ticks(1);
    check_pos("rwall_back", 631, 117);

    // Top wall.
    ticks(114);
    check_pos("twall_pre", 517, 3);
    ticks(2);
    check_pos("twall_1", 515, 1);
    check("twall_1_dir", 16'(dir_y), 16'd0);
    ticks(1);
    check_pos("twall", 514, 0);
    check("twall_dir", 16'(dir_y), 16'd1);

    // Descend left, brick_hit_x on a tick flips toward the paddle.
    ticks(323);
    check_pos("descend", 191, 323);
    brick_hit_x = 1'b1;
    ticks(1);
    brick_hit_x = 1'b0;
    check_pos("brick_x", 192, 324);
    check("brick_x_dir", 16'(dir_x), 16'd1);

    // Paddle hit at y=431.
    ticks(107);
    check_pos("pad_pre", 299, 431);
    ticks(1);
    check_pos("pad_hit", 300, 432);
    check("pad_hit_dir", 16'(dir_y), 16'd0);
    check("pad_hit_moving", 16'(moving), 16'd1);

    // Miss: paddle moved away, ball turned down by a brick hit.
    paddle_x    = 10'd0;
    brick_hit_y = 1'b1;
    ticks(1);
    brick_hit_y = 1'b0;
    check_pos("miss_turn", 301, 433);
    check("miss_turn_dir", 16'(dir_y), 16'd1);
    ticks(38);
    check_pos("miss_pre", 339, 471);
    check("miss_pre_lost", 16'(ball_lost), 16'd0);
    ticks(1);
    check("lost_y", 16'(ball_y), 16'd472);
    check("lost_pulse", 16'(ball_lost), 16'd1);
    check("lost_moving", 16'(moving), 16'd0);
    check("lost_state", 16'(dbg_state), 16'd2);
    launch = 1'b1;
    cyc(1);
    launch = 1'b0;
    check("lost_end", 16'(ball_lost), 16'd0);
    check("lost_to_idle", 16'(dbg_state), 16'd0);
    cyc(1);
    check_pos("retrack", 28, 432);
    check("retrack_moving", 16'(moving), 16'd0);
    check("retrack_lost", 16'(ball_lost), 16'd0);

    // Asynchronous reset mid-motion.
    paddle_x = 10'd288;
    launch   = 1'b1;
    cyc(1);
    launch = 1'b0;
    ticks(5);
    check_pos("pre_reset", 321, 427);
    #3;
    reset = 1'b0;
    #1;
    check_pos("async_rst", 0, 432);
    check("async_rst_dir_x", 16'(dir_x), 16'd1);
    check("async_rst_dir_y", 16'(dir_y), 16'd0);
    check("async_rst_moving", 16'(moving), 16'd0);
    check("async_rst_lost", 16'(ball_lost), 16'd0);
    check("async_rst_state", 16'(dbg_state), 16'd0);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    check_pos("post_reset", 316, 432);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
